// File: rtl/bsram_fifo_pkg.sv
// bsram_fifo_pkg
// Shared constants and types for the single-port block-RAM streaming FIFO
// controller and its output register FIFO.
//   DW_DEFAULT / AW_DEFAULT : default word width and RAM address width
//   OBUF_DEPTH              : entries in the output register FIFO (fixed)
//   op_t                    : last executed RAM operation, used for
//                             round-robin arbitration between write and read
package bsram_fifo_pkg;

    localparam int DW_DEFAULT = 36;
    localparam int AW_DEFAULT = 10;
    localparam int OBUF_DEPTH = 3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/bsram_fifo_obuf.sv
// bsram_fifo_obuf
// Three-entry register FIFO that receives words read back from the block
// RAM and presents the head word to the downstream consumer.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (clears entries too)
//   push       : write push_data this cycle
//   push_data  : word to store
//   pop        : remove head word this cycle (ignored when empty)
//   head       : current head word (0 after reset)
//   valid      : buffer holds at least one word
//   count      : number of words held (0..3)
module bsram_fifo_obuf
    import bsram_fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [OBUF_DEPTH];
    logic [1:0]    rd_idx;
    logic [1:0]    wr_idx;
    logic          pop_eff;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'(OBUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign pop_eff = pop && (count != 2'd0);
    assign head    = mem[rd_idx];
    assign valid   = (count != 2'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_idx <= 2'd0;
            wr_idx <= 2'd0;
            count  <= 2'd0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= next_idx(wr_idx);
            end
            if (pop_eff) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({push, pop_eff})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bsram_fifo_ctrl.sv
// bsram_fifo_ctrl
// Drives a single-port block RAM (registered read data) as a streaming
// FIFO. Input words are written into the RAM, read back in order and
// staged in a 3-entry output buffer. One RAM access per cycle; write and
// read alternate under contention.
// Ports:
//   CLK, RESET        : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : input stream
//   m_data/m_valid/m_ready : output stream (head of output buffer)
//   ram_di/ram_ad/ram_wre/ram_ce : RAM drive; ram_do: RAM read data,
//                       valid the cycle after a read access
//   level             : words held in RAM + in-flight read + output buffer
module bsram_fifo_ctrl
    import bsram_fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ad,
    output logic          ram_wre,
    output logic          ram_ce,
    input  logic [DW-1:0] ram_do,
    output logic [AW+1:0] level
);

    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_count;
    logic          rd_pend;
    op_t           last_op;

    logic [1:0]    obuf_count;
    logic          obuf_push;
    logic          obuf_pop;
    logic [2:0]    credit;
    logic          wr_ok;
    logic          rd_elig;
    logic          do_wr;
    logic          do_rd;

    // Credit ignores a same-cycle pop so m_ready never reaches the RAM drive.
    assign credit  = 3'(obuf_count) + 3'(rd_pend);
    assign wr_ok   = ram_count < (AW+1)'(DEPTH);
    assign rd_elig = (ram_count != '0) && (credit < 3'(OBUF_DEPTH));

    // Writes yield to a pending read only when the previous access was a write.
    assign s_ready = !RESET && wr_ok && !(rd_elig && last_op == OP_WRITE);
    assign do_wr   = s_valid && s_ready;
    assign do_rd   = !RESET && rd_elig && !do_wr;

    assign ram_ce  = do_wr || do_rd;
    assign ram_wre = do_wr;
    assign ram_ad  = do_wr ? wr_ptr : rd_ptr;
    assign ram_di  = s_data;

    assign level = RESET ? '0
                 : (AW+2)'(ram_count) + (AW+2)'(rd_pend) + (AW+2)'(obuf_count);

    // RAM access stage: pointer/count update and read-pending flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            rd_pend   <= 1'b0;
            last_op   <= OP_READ;
        end else begin
            rd_pend <= do_rd;
            if (do_wr) begin
                wr_ptr    <= wr_ptr + 1'b1;
                ram_count <= ram_count + 1'b1;
                last_op   <= OP_WRITE;
            end else if (do_rd) begin
                rd_ptr    <= rd_ptr + 1'b1;
                ram_count <= ram_count - 1'b1;
                last_op   <= OP_READ;
            end
        end
    end

    // Capture stage: RAM read data lands in the output buffer.
    assign obuf_push = rd_pend;
    assign obuf_pop  = m_valid && m_ready;

    bsram_fifo_obuf #(.DW(DW)) u_obuf (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (obuf_push),
        .push_data (ram_do),
        .pop       (obuf_pop),
        .head      (m_data),
        .valid     (m_valid),
        .count     (obuf_count)
    );

endmodule

// File: tb/tb_bsram_fifo_ctrl.sv
module tb_bsram_fifo_ctrl;
    localparam int DW = 36;
    localparam int AW = 10;
    localparam int FULL_LEVEL = 1027;

    logic          CLK;
    logic          RESET;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ad;
    logic          ram_wre;
    logic          ram_ce;
    logic [DW-1:0] ram_do;
    logic [AW+1:0] level;

    bsram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .ram_di  (ram_di),
        .ram_ad  (ram_ad),
        .ram_wre (ram_wre),
        .ram_ce  (ram_ce),
        .ram_do  (ram_do),
        .level   (level)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single-port RAM with registered read; idle cycles produce junk.
    logic [DW-1:0] ram_mem [1024];
    always @(posedge CLK) begin
        if (ram_ce) begin
            if (ram_wre) ram_mem[ram_ad] <= ram_di;
            else         ram_do <= ram_mem[ram_ad];
        end else begin
            ram_do <= 36'({$urandom(), $urandom()});
        end
    end

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: the reference FIFO is exp_q; its size is the level.
    always @(negedge CLK) begin
        if (RESET) begin
            exp_q.delete();
        end else begin
            chk("level_model", 64'(level), 64'(exp_q.size()));
            chk("wre_without_ce", 64'(ram_wre && !ram_ce), 64'd0);
            chk("obuf_overflow",
                64'(dut.obuf_push && dut.obuf_count == 2'd3 && !dut.obuf_pop), 64'd0);
            if (exp_q.size() == 0) chk("m_valid_when_empty", 64'(m_valid), 64'd0);
            if (exp_q.size() == FULL_LEVEL) chk("s_ready_when_full", 64'(s_ready), 64'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_with_no_expected_word", 64'd1, 64'd0);
                end else begin
                    chk("m_data_order", 64'(m_data), 64'(exp_q.pop_front()));
                end
                npop++;
            end
            if (s_valid && s_ready) exp_q.push_back(s_data);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (level == '0 && !m_valid) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        next_cycle();
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin
        int nacc;
        int p0;
        logic seen_top;
        logic wrapped;
        logic got;
        logic [DW-1:0] wordb;

        RESET   = 1'b1;
        s_valid = 1'b1;
        s_data  = 36'h123456789;
        m_ready = 1'b0;

        // Reset with s_valid held high.
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_ram_ce", 64'(ram_ce), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_level", 64'(level), 64'd0);
            next_cycle();
        end
        RESET   = 1'b0;
        s_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        next_cycle();

        // Single word latency and RAM drive.
        s_valid = 1'b1;
        s_data  = 36'h9ABCD1234;
        m_ready = 1'b1;
        @(negedge CLK);
        chk("sw_t_wre", 64'(ram_wre), 64'd1);
        chk("sw_t_ce", 64'(ram_ce), 64'd1);
        chk("sw_t_ad", 64'(ram_ad), 64'd0);
        next_cycle();
        s_valid = 1'b0;
        @(negedge CLK);
        chk("sw_t1_ce", 64'(ram_ce), 64'd1);
        chk("sw_t1_wre", 64'(ram_wre), 64'd0);
        chk("sw_t1_ad", 64'(ram_ad), 64'd0);
        next_cycle();
        @(negedge CLK);
        chk("sw_t2_m_valid", 64'(m_valid), 64'd0);
        next_cycle();
        @(negedge CLK);
        chk("sw_t3_m_valid", 64'(m_valid), 64'd1);
        chk("sw_t3_m_data", 64'(m_data), 64'h9ABCD1234);
        next_cycle();
        @(negedge CLK);
        chk("sw_level_after", 64'(level), 64'd0);
        next_cycle();

        // Fill until full with consumer stalled.
        m_ready = 1'b0;
        s_valid = 1'b1;
        nacc    = 0;
        s_data  = '0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge CLK);
            if (s_ready) nacc++;
            next_cycle();
            s_data = 36'(nacc);
        end
        s_valid = 1'b0;
        @(negedge CLK);
        chk("fill_accepted", 64'(nacc), 64'(FULL_LEVEL));
        chk("fill_level", 64'(level), 64'(FULL_LEVEL));
        chk("fill_s_ready", 64'(s_ready), 64'd0);
        next_cycle();

        // Drain everything in order.
        p0      = npop;
        m_ready = 1'b1;
        wait_empty("drain_timeout", 1300);
        chk("drain_count", 64'(npop - p0), 64'(FULL_LEVEL));
        @(negedge CLK);
        chk("drain_m_valid", 64'(m_valid), 64'd0);
        chk("drain_level", 64'(level), 64'd0);
        next_cycle();

        // Contention: preload 13 words (10 stay in RAM), then stream both ways.
        m_ready = 1'b0;
        s_valid = 1'b1;
        nacc    = 0;
        for (int c = 0; c < 100 && nacc < 13; c++) begin
            s_data = 36'({$urandom(), $urandom()});
            @(negedge CLK);
            if (s_ready) nacc++;
            next_cycle();
        end
        s_valid = 1'b0;
        for (int c = 0; c < 4; c++) next_cycle();
        @(negedge CLK);
        chk("cont_preload_level", 64'(level), 64'd13);
        next_cycle();
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 36'({$urandom(), $urandom()});
            @(negedge CLK);
            chk("cont_wre_pattern", 64'(ram_wre), 64'((i % 2) == 0));
            chk("cont_ce", 64'(ram_ce), 64'd1);
            next_cycle();
        end
        s_valid = 1'b0;
        wait_empty("cont_drain_timeout", 200);

        // Wrap: random traffic of 2500 words.
        nacc     = 0;
        seen_top = 1'b0;
        wrapped  = 1'b0;
        for (int c = 0; c < 20000 && nacc < 2500; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = 36'({$urandom(), $urandom()});
            @(negedge CLK);
            if (s_valid && s_ready) nacc++;
            if (ram_ce && ram_ad == 10'd1023) seen_top = 1'b1;
            if (ram_ce && ram_ad == 10'd0 && seen_top) wrapped = 1'b1;
            next_cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("wrap_accepted", 64'(nacc), 64'd2500);
        wait_empty("wrap_drain_timeout", 1300);
        chk("wrap_address_wrapped", 64'(wrapped), 64'd1);

        // Reset while a read is in flight.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 36'hA5A5A5A5A;
        @(negedge CLK);
        chk("rmr_write", 64'(ram_wre), 64'd1);
        next_cycle();
        s_valid = 1'b0;
        @(negedge CLK);
        chk("rmr_read_ce", 64'(ram_ce), 64'd1);
        chk("rmr_read_wre", 64'(ram_wre), 64'd0);
        next_cycle();
        RESET = 1'b1;
        @(negedge CLK);
        next_cycle();
        RESET   = 1'b0;
        m_ready = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (m_valid) got = 1'b1;
            chk("rmr_level", 64'(level), 64'd0);
            next_cycle();
        end
        chk("rmr_no_stale_word", 64'(got), 64'd0);

        wordb   = 36'h0FEDCBA98;
        s_valid = 1'b1;
        s_data  = wordb;
        @(negedge CLK);
        chk("rmr_new_write_ad", 64'(ram_ad), 64'd0);
        chk("rmr_new_write_wre", 64'(ram_wre), 64'd1);
        next_cycle();
        s_valid = 1'b0;
        @(negedge CLK);
        chk("rmr_new_read_ad", 64'(ram_ad), 64'd0);
        chk("rmr_new_read_ce", 64'(ram_ce && !ram_wre), 64'd1);
        next_cycle();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (m_valid) begin
                got = 1'b1;
                chk("rmr_new_data", 64'(m_data), 64'(wordb));
            end
            next_cycle();
        end
        chk("rmr_new_word_seen", 64'(got), 64'd1);
        wait_empty("final_drain_timeout", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
